// File: rtl/sm_debug_ctrl.sv
// Board-level debug controller: debounced step/mode buttons, single-step clock enable
// sequencing, and manual or auto-scan selection of the register shown on the display.
module sm_debug_ctrl #(
    parameter int unsigned DEBOUNCE_W  = 16,
    parameter int unsigned STEP_CYCLES = 64,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned DWELL_W     = 24,
    parameter int unsigned SKIP_ZERO   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btnStep_n,
    input  logic        btnMode_n,
    input  logic        runSw,
    input  logic [4:0]  manualAddr,
    input  logic [31:0] regData,
    output logic        clkEnable,
    output logic [4:0]  regAddr,
    output logic [4:0]  dispAddr,
    output logic [31:0] dispData,
    output logic        scanMode
);

    localparam int unsigned StepW   = $clog2(STEP_CYCLES + 1);
    localparam int unsigned SettleW = $clog2(SETTLE + 1);
    localparam logic [4:0]  WrapIdx = (SKIP_ZERO != 0) ? 5'd1 : 5'd0;

    typedef enum logic [1:0] {StManual, StScanSet, StScanWait, StScanDwell} state_e;

    logic [1:0] btn_raw;
    logic [1:0] press;
    logic       step_press;
    logic       mode_press;

    assign btn_raw    = {btnMode_n, btnStep_n};
    assign step_press = press[0];
    assign mode_press = press[1];

    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic                  sync1_q, sync2_q;
        logic                  level_q;
        logic                  armed_q;
        logic [DEBOUNCE_W-1:0] cnt_q;
        logic                  pressed_sync;
        logic                  saturated;

        assign pressed_sync = ~sync2_q;
        assign saturated    = &cnt_q;

        // Synchroniser resets to "pressed" and armed_q gates events, so a button held
        // through reset has to be seen released before it can produce a press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                armed_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= btn_raw[i];
                sync2_q <= sync1_q;
                armed_q <= armed_q | sync2_q;
                if (pressed_sync == level_q) begin
                    cnt_q <= '0;
                end else if (saturated) begin
                    level_q <= pressed_sync;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign press[i] = pressed_sync & ~level_q & saturated & armed_q;
    end

    logic [StepW-1:0] step_cnt_q, step_cnt_d;
    logic             clk_en_q;

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (step_press && !runSw && step_cnt_q == '0) begin
            step_cnt_d = StepW'(STEP_CYCLES);
        end else if (step_cnt_q != '0) begin
            step_cnt_d = step_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= '0;
            clk_en_q   <= 1'b0;
        end else begin
            step_cnt_q <= step_cnt_d;
            clk_en_q   <= runSw | (step_cnt_d != '0);
        end
    end

    state_e             state_q, state_d;
    logic [4:0]         reg_addr_q, reg_addr_d;
    logic [4:0]         disp_addr_q, disp_addr_d;
    logic [31:0]        disp_data_q, disp_data_d;
    logic [4:0]         scan_idx_q, scan_idx_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StManual;
        end else begin
            state_q <= state_d;
        end
    end

    // A mode press overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            state_d = (state_q == StManual) ? StScanSet : StManual;
        end else begin
            unique case (state_q)
                StManual:    state_d = StManual;
                StScanSet:   state_d = StScanWait;
                StScanWait:  if (settle_q == '0) state_d = StScanDwell;
                StScanDwell: if (&dwell_q) state_d = StScanSet;
                default:     state_d = StManual;
            endcase
        end
    end

    always_comb begin
        reg_addr_d  = reg_addr_q;
        disp_addr_d = disp_addr_q;
        disp_data_d = disp_data_q;
        scan_idx_d  = scan_idx_q;
        settle_d    = settle_q;
        dwell_d     = dwell_q;
        if (!mode_press) begin
            unique case (state_q)
                StManual: begin
                    reg_addr_d  = manualAddr;
                    disp_addr_d = manualAddr;
                    disp_data_d = regData;
                end
                StScanSet: begin
                    reg_addr_d = scan_idx_q;
                    settle_d   = SettleW'(SETTLE);
                end
                StScanWait: begin
                    if (settle_q == '0) begin
                        disp_data_d = regData;
                        disp_addr_d = scan_idx_q;
                        dwell_d     = '0;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                StScanDwell: begin
                    if (&dwell_q) begin
                        scan_idx_d = (scan_idx_q == 5'd31) ? WrapIdx : scan_idx_q + 1'b1;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr_q  <= '0;
            disp_addr_q <= '0;
            disp_data_q <= '0;
            scan_idx_q  <= WrapIdx;
            settle_q    <= '0;
            dwell_q     <= '0;
        end else begin
            reg_addr_q  <= reg_addr_d;
            disp_addr_q <= disp_addr_d;
            disp_data_q <= disp_data_d;
            scan_idx_q  <= scan_idx_d;
            settle_q    <= settle_d;
            dwell_q     <= dwell_d;
        end
    end

    always_comb begin
        scanMode  = (state_q != StManual);
        clkEnable = clk_en_q;
        regAddr   = reg_addr_q;
        dispAddr  = disp_addr_q;
        dispData  = disp_data_q;
    end

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Directed bench for sm_debug_ctrl: debounce, single-step, run, manual and scan display.
module tb_sm_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btnStep_n;
    logic        btnMode_n;
    logic        runSw;
    logic [4:0]  manualAddr;
    logic [31:0] regData;
    logic        clkEnable;
    logic [4:0]  regAddr;
    logic [4:0]  dispAddr;
    logic [31:0] dispData;
    logic        scanMode;

    logic        use_model;
    logic [31:0] const_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Register file model: value of register n is 3*n.
    assign regData = use_model ? ({27'b0, regAddr} * 32'd3) : const_data;

    sm_debug_ctrl #(
        .DEBOUNCE_W (2),
        .STEP_CYCLES(3),
        .SETTLE     (2),
        .DWELL_W    (3),
        .SKIP_ZERO  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btnStep_n (btnStep_n),
        .btnMode_n (btnMode_n),
        .runSw     (runSw),
        .manualAddr(manualAddr),
        .regData   (regData),
        .clkEnable (clkEnable),
        .regAddr   (regAddr),
        .dispAddr  (dispAddr),
        .dispData  (dispData),
        .scanMode  (scanMode)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_en(input int n, output int c);
        c = 0;
        repeat (n) begin
            tick(1);
            if (clkEnable === 1'b1) c++;
        end
    endtask

    initial begin
        int c0, c1, c2, k;
        int expect_idx, last_addr, nchg, bad_inv, bad_period, cyc, last_cyc;

        rst_n      = 1'b0;
        btnStep_n  = 1'b0;
        btnMode_n  = 1'b1;
        runSw      = 1'b0;
        manualAddr = 5'd0;
        use_model  = 1'b0;
        const_data = 32'd0;

        #12;
        check("rst_clkEnable", clkEnable, 0);
        check("rst_regAddr", regAddr, 0);
        check("rst_dispAddr", dispAddr, 0);
        check("rst_dispData", dispData, 0);
        check("rst_scanMode", scanMode, 0);

        // Step button held through reset must not step.
        @(negedge clk);
        rst_n = 1'b1;
        count_en(20, c0);
        check("held_through_reset", c0, 0);
        btnStep_n = 1'b1;
        count_en(10, c0);
        check("release_no_step", c0, 0);

        btnStep_n = 1'b0;
        count_en(2, c0);
        btnStep_n = 1'b1;
        count_en(20, c1);
        check("glitch_ignored", c0 + c1, 0);

        btnStep_n = 1'b0;
        count_en(10, c0);
        btnStep_n = 1'b1;
        count_en(15, c1);
        check("single_step_3", c0 + c1, 3);

        // Bouncy press still gives a single step.
        btnStep_n = 1'b0;
        count_en(2, c0);
        btnStep_n = 1'b1;
        count_en(1, c1);
        btnStep_n = 1'b0;
        count_en(10, c2);
        btnStep_n = 1'b1;
        c0 = c0 + c1 + c2;
        count_en(15, c1);
        check("bouncy_step_3", c0 + c1, 3);

        runSw = 1'b1;
        tick(1);
        count_en(5, c0);
        check("run_const_high", c0, 5);
        btnStep_n = 1'b0;
        count_en(10, c0);
        btnStep_n = 1'b1;
        count_en(8, c1);
        check("run_with_press", c0 + c1, 18);
        runSw = 1'b0;
        tick(1);
        check("run_off", clkEnable, 0);
        count_en(10, c0);
        check("press_in_run_dropped", c0, 0);

        const_data = 32'hDEAD_BEEF;
        manualAddr = 5'd5;
        tick(1);
        check("manual_regAddr", regAddr, 5);
        tick(1);
        check("manual_dispData", dispData, 32'hDEAD_BEEF);
        check("manual_dispAddr", dispAddr, 5);
        check("manual_scanMode", scanMode, 0);

        use_model = 1'b1;
        tick(1);
        btnMode_n = 1'b0;
        k = 0;
        while (scanMode !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("enter_scan", scanMode, 1);
        btnMode_n = 1'b1;

        expect_idx = 1;
        last_addr  = int'(dispAddr);
        nchg       = 0;
        bad_inv    = 0;
        bad_period = 0;
        cyc        = 0;
        last_cyc   = 0;
        while (nchg < 32 && cyc < 600) begin
            tick(1);
            cyc++;
            if (dispData !== {27'b0, dispAddr} * 32'd3) bad_inv++;
            if (int'(dispAddr) != last_addr) begin
                check("scan_addr_seq", dispAddr, expect_idx);
                if (nchg > 0 && cyc - last_cyc != 12) bad_period++;
                last_cyc   = cyc;
                last_addr  = int'(dispAddr);
                expect_idx = (expect_idx == 31) ? 1 : expect_idx + 1;
                nchg++;
            end
        end
        check("scan_capture_count", nchg, 32);
        check("scan_data_3x", bad_inv, 0);
        check("scan_period_12", bad_period, 0);
        check("scan_mode_held", scanMode, 1);

        k = 0;
        while (dispAddr !== 5'd7 && k < 200) begin
            tick(1);
            k++;
        end
        check("reach_idx7", dispAddr, 7);
        btnMode_n = 1'b0;
        k = 0;
        while (scanMode !== 1'b0 && k < 20) begin
            tick(1);
            k++;
        end
        check("exit_scan", scanMode, 0);
        check("exit_within_dwell", (k < 8) ? 1 : 0, 1);
        check("exit_dispAddr", dispAddr, 7);
        btnMode_n  = 1'b1;
        manualAddr = 5'd9;
        tick(10);
        check("manual2_regAddr", regAddr, 9);
        check("manual2_dispAddr", dispAddr, 9);
        check("manual2_dispData", dispData, 27);

        btnMode_n = 1'b0;
        k = 0;
        while (scanMode !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("reenter_scan", scanMode, 1);
        btnMode_n = 1'b1;
        k = 0;
        while (dispAddr === 5'd9 && k < 30) begin
            tick(1);
            k++;
        end
        check("resume_idx", dispAddr, 7);
        check("resume_data", dispData, 21);

        btnStep_n = 1'b0;
        k = 0;
        while (clkEnable !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("step_before_reset", clkEnable, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_clkEnable", clkEnable, 0);
        check("async_rst_scanMode", scanMode, 0);
        check("async_rst_regAddr", regAddr, 0);
        check("async_rst_dispAddr", dispAddr, 0);
        check("async_rst_dispData", dispData, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_en(15, c0);
        check("step_aborted", c0, 0);
        btnStep_n = 1'b1;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
